// File: rtl/axi_order_pkg.sv
`default_nettype none
// ============================================================================
// axi_order_pkg : slave index constants and one-hot helpers for read ordering
// Rev 1.0
// ============================================================================
package axi_order_pkg;

  typedef logic [1:0] slv_idx_t;

  localparam slv_idx_t SLV_S0 = 2'd0;
  localparam slv_idx_t SLV_S1 = 2'd1;
  localparam slv_idx_t SLV_S2 = 2'd2;
  localparam slv_idx_t SLV_SD = 2'd3;

  localparam int DEPTH_DEFAULT = 8;

  // SD has no ordered grant line, so it maps to all-zero
  function automatic logic [2:0] idx2oh(input slv_idx_t idx);
    logic [2:0] oh;
    oh = 3'b000;
    case (idx)
      SLV_S0:  oh = 3'b001;
      SLV_S1:  oh = 3'b010;
      SLV_S2:  oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  function automatic logic oh_valid(input logic [3:0] vec);
    return (vec != 4'b0000) && ((vec & (vec - 4'b0001)) == 4'b0000);
  endfunction

  function automatic slv_idx_t oh2idx(input logic [2:0] oh);
    slv_idx_t idx;
    idx = SLV_S0;
    if (oh[1]) idx = SLV_S1;
    if (oh[2]) idx = SLV_S2;
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_order_fifo.sv
`default_nettype none
// ============================================================================
// axi_order_fifo : generic synchronous circular FIFO with head-data read
// Rev 1.0
// ============================================================================
module axi_order_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[head_q];

  // A push at full is accepted only when the same cycle frees a slot
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[tail_q] = wdata;
      tail_d        = tail_q + 1'b1;
    end
    if (do_pop) begin
      head_d = head_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_r_order_tracker.sv
`default_nettype none
// ============================================================================
// axi_r_order_tracker : issue-order tracker granting R return to oldest slave
// Rev 1.0
// ============================================================================
module axi_r_order_tracker
  import axi_order_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int W_CNT = $clog2(DEPTH) + 1
) (
  input  logic             AXI_CLK,
  input  logic             AXI_RST,
  input  logic             AR_VALID,
  input  logic             AR_READY,
  input  logic [3:0]       AR_SEL,
  input  logic             R_DONE,
  input  logic [3:0]       R_DONE_SEL,
  output logic [2:0]       r_order_grant,
  output logic             ar_hold,
  output logic [W_CNT-1:0] outstanding,
  output logic             order_err
);

  localparam logic [3:0] SEL_SD = 4'b1000;

  logic             ar_hs;
  logic             ar_is_sd;
  logic             ar_tracked;
  logic             push_req;
  logic             r_is_sd;
  logic             pop_ok;
  logic             sel_err;
  logic             push_err;
  logic             pop_err;
  slv_idx_t         head_idx;
  slv_idx_t         push_idx;
  logic             fifo_full;
  logic             fifo_empty;
  logic [W_CNT-1:0] fifo_count;
  logic             order_err_q, order_err_d;

  assign ar_hs      = AR_VALID & AR_READY;
  assign ar_is_sd   = (AR_SEL == SEL_SD);
  assign ar_tracked = oh_valid(AR_SEL) & ~AR_SEL[3];
  assign push_req   = ar_hs & ar_tracked;
  assign push_idx   = oh2idx(AR_SEL[2:0]);

  // Only a completion from the exact head slave retires an entry
  assign r_is_sd = (R_DONE_SEL == SEL_SD);
  assign pop_ok  = R_DONE & ~fifo_empty & (R_DONE_SEL == {1'b0, idx2oh(head_idx)});

  assign sel_err  = ar_hs & ~ar_tracked & ~ar_is_sd;
  assign push_err = push_req & fifo_full & ~pop_ok;
  assign pop_err  = R_DONE & ~r_is_sd & ~pop_ok;

  axi_order_fifo #(
    .WIDTH (2),
    .DEPTH (DEPTH),
    .CNT_W (W_CNT)
  ) u_fifo (
    .clk   (AXI_CLK),
    .rst   (AXI_RST),
    .push  (push_req),
    .pop   (pop_ok),
    .wdata (push_idx),
    .rdata (head_idx),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    order_err_d = order_err_q | sel_err | push_err | pop_err;
  end

  always_ff @(posedge AXI_CLK) begin
    if (AXI_RST) begin
      order_err_q <= 1'b0;
    end else begin
      order_err_q <= order_err_d;
    end
  end

  // Grant depends only on FIFO registers, never on this cycle's inputs
  assign r_order_grant = fifo_empty ? 3'b000 : idx2oh(head_idx);
  assign ar_hold       = fifo_full;
  assign outstanding   = fifo_count;
  assign order_err     = order_err_q;

endmodule
`default_nettype wire
